// File: rtl/table_lookup_pkg.sv
// Shared definitions for the AES T-table lookup pipeline: mode encodings,
// GF(2^8) arithmetic and the forward/inverse S-box computed from the field inverse.
package table_lookup_pkg;

    localparam logic [1:0] MODE_ENC  = 2'b00;
    localparam logic [1:0] MODE_DEC  = 2'b01;
    localparam logic [1:0] MODE_LAST = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul_full(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] t;
        acc = 8'h00;
        t   = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? t : 8'h00);
            t   = xtime(t);
        end
        return acc;
    endfunction

    // Field inverse as a^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] e;
        r = 8'h01;
        e = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul_full(r, r);
            r = e[i] ? gf_mul_full(r, a) : r;
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] coef);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] r;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (coef)
            4'h1:    r = a;
            4'h2:    r = x2;
            4'h3:    r = x2 ^ a;
            4'h9:    r = x8 ^ a;
            4'hb:    r = x8 ^ x2 ^ a;
            4'hd:    r = x8 ^ x4 ^ a;
            4'he:    r = x8 ^ x4 ^ x2;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tbox_byte.sv
// One state byte through both pipeline stages: substitution, then the
// 32-bit lookup word for byte position idx.
module tbox_byte
    import table_lookup_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ld1,
    input  logic        ld2,
    input  logic [1:0]  mode,
    input  logic [1:0]  mode1,
    input  logic [1:0]  idx,
    input  logic [7:0]  x,
    output logic [31:0] word
);

    logic [7:0]  sub_s;
    logic [7:0]  s_r;
    logic [31:0] base_s;
    logic [31:0] word_s;
    logic [31:0] word_r;

    // Inverse S-box only for decrypt; reserved mode output is zeroed later
    always_comb begin
        sub_s = 8'h00;
        if (mode == MODE_DEC) begin
            sub_s = inv_sbox(x);
        end else begin
            sub_s = sbox(x);
        end
    end

    // Stage-1 substituted byte
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r <= 8'h00;
        end else if (ld1) begin
            s_r <= sub_s;
        end
    end

    // Word for byte position 0; other positions are byte rotations of it
    always_comb begin
        base_s = 32'h0000_0000;
        case (mode1)
            MODE_ENC:  base_s = {gf_mul(s_r, 4'h2), s_r, s_r, gf_mul(s_r, 4'h3)};
            MODE_DEC:  base_s = {gf_mul(s_r, 4'he), gf_mul(s_r, 4'h9),
                                 gf_mul(s_r, 4'hd), gf_mul(s_r, 4'hb)};
            MODE_LAST: base_s = {s_r, 24'h00_0000};
            default:   base_s = 32'h0000_0000;
        endcase
    end

    // Rotate right by idx bytes
    always_comb begin
        word_s = base_s;
        case (idx)
            2'd0:    word_s = base_s;
            2'd1:    word_s = {base_s[7:0],  base_s[31:8]};
            2'd2:    word_s = {base_s[15:0], base_s[31:16]};
            2'd3:    word_s = {base_s[23:0], base_s[31:24]};
            default: word_s = base_s;
        endcase
    end

    // Stage-2 output word
    always_ff @(posedge clk) begin
        if (rst) begin
            word_r <= 32'h0000_0000;
        end else if (ld2) begin
            word_r <= word_s;
        end
    end

    assign word = word_r;

endmodule

// File: rtl/table_lookup_pipe.sv
// Two-stage valid/ready AES T-table lookup over LANES state words per beat;
// holds the flow control, the mode pipeline and the sticky reserved-mode flag.
module table_lookup_pipe
    import table_lookup_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mode,
    input  logic [32*LANES-1:0]   in_state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_mode,
    output logic [32*LANES-1:0]   p0,
    output logic [32*LANES-1:0]   p1,
    output logic [32*LANES-1:0]   p2,
    output logic [32*LANES-1:0]   p3,
    output logic                  err
);

    logic                        v1_r;
    logic                        v2_r;
    logic [1:0]                  mode1_r;
    logic [1:0]                  mode2_r;
    logic                        err_r;
    logic                        ld1_s;
    logic                        ld2_s;
    logic                        acc_s;
    logic                        adv_s;
    logic [LANES-1:0][3:0][31:0] word_s;

    assign ld2_s = !v2_r || out_ready;
    assign ld1_s = !v1_r || ld2_s;
    assign acc_s = in_valid && ld1_s;
    // Data registers only move for real beats so held outputs stay clean
    assign adv_s = ld2_s && v1_r;

    // Stage valids, mode pipeline and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r    <= 1'b0;
            v2_r    <= 1'b0;
            mode1_r <= MODE_ENC;
            mode2_r <= MODE_ENC;
            err_r   <= 1'b0;
        end else begin
            if (ld1_s) begin
                v1_r <= in_valid;
            end
            if (acc_s) begin
                mode1_r <= in_mode;
            end
            if (ld2_s) begin
                v2_r <= v1_r;
            end
            if (adv_s) begin
                mode2_r <= mode1_r;
            end
            if (acc_s && (in_mode == MODE_RSVD)) begin
                err_r <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        for (genvar i = 0; i < 4; i++) begin : g_byte
            tbox_byte u_tbox (
                .clk   (clk),
                .rst   (rst),
                .ld1   (acc_s),
                .ld2   (adv_s),
                .mode  (in_mode),
                .mode1 (mode1_r),
                .idx   (2'(i)),
                .x     (in_state[32*k+31-8*i -: 8]),
                .word  (word_s[k][i])
            );
        end
        assign p0[32*k +: 32] = word_s[k][0];
        assign p1[32*k +: 32] = word_s[k][1];
        assign p2[32*k +: 32] = word_s[k][2];
        assign p3[32*k +: 32] = word_s[k][3];
    end

    assign in_ready  = ld1_s;
    assign out_valid = v2_r;
    assign out_mode  = mode2_r;
    assign err       = err_r;

endmodule

// File: tb/tb_table_lookup_pipe.sv
// Scoreboard bench for table_lookup_pipe with two lanes; the reference model
// builds its S-box by brute-force field inversion plus the affine map.
module tb_table_lookup_pipe;

    localparam int LANES = 2;
    localparam int W     = 32 * LANES;

    typedef struct packed {
        logic [1:0]        mode;
        logic [3:0][W-1:0] p;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_mode = 2'b00;
    logic [W-1:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [1:0]   out_mode;
    logic [W-1:0] p0, p1, p2, p3;
    logic         err;

    int    vectors = 0;
    int    miscompares = 0;
    beat_t sb_q[$];
    logic [7:0] sb_t [256];
    logic [7:0] isb_t [256];

    table_lookup_pipe #(.LANES(LANES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_state(in_state), .out_valid(out_valid),
        .out_ready(out_ready), .out_mode(out_mode), .p0(p0), .p1(p1),
        .p2(p2), .p3(p3), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] t;
        acc = 8'h00;
        t = a;
        for (int j = 0; j < 8; j++) begin
            if (b[j]) acc = acc ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic beat_t model(input logic [1:0] m, input logic [W-1:0] st);
        beat_t r;
        logic [7:0] x, s;
        logic [31:0] base;
        r.mode = m;
        r.p = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int i = 0; i < 4; i++) begin
                x = st[32*k+31-8*i -: 8];
                s = (m == 2'b01) ? isb_t[x] : sb_t[x];
                case (m)
                    2'b00:   base = {mul(s, 8'h02), s, s, mul(s, 8'h03)};
                    2'b01:   base = {mul(s, 8'h0e), mul(s, 8'h09), mul(s, 8'h0d), mul(s, 8'h0b)};
                    2'b10:   base = {s, 24'h000000};
                    default: base = 32'h0;
                endcase
                r.p[i][32*k +: 32] = (i == 0) ? base : ((base >> (8*i)) | (base << (32 - 8*i)));
            end
        end
        return r;
    endfunction

    // Scoreboard: pop/compare on every output handshake, push on every input handshake
    always @(negedge clk) begin
        beat_t e;
        logic [3:0][W-1:0] got;
        if (!rst && out_valid && out_ready) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat: got beat mode %b, required none", out_mode);
            end else begin
                e = sb_q.pop_front();
                got = {p3, p2, p1, p0};
                if (out_mode !== e.mode) begin
                    miscompares++;
                    $display("FAIL sb_mode: got %b, required %b", out_mode, e.mode);
                end
                for (int w = 0; w < 4; w++) begin
                    vectors++;
                    if (got[w] !== e.p[w]) begin
                        miscompares++;
                        $display("FAIL sb_p%0d: got %h, required %h", w, got[w], e.p[w]);
                    end
                end
            end
        end
        if (!rst && in_valid && in_ready) sb_q.push_back(model(in_mode, in_state));
    end

    task automatic send(input logic [1:0] m, input logic [W-1:0] st, input bit rnd);
        int n;
        bit acc;
        in_valid = 1'b1;
        in_mode = m;
        in_state = st;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        end while (!acc && n < 100);
        in_valid = 1'b0;
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL send_timeout: got no acceptance, required acceptance within 100 cycles");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d beats outstanding, required 0", sb_q.size());
        end
    endtask

    task automatic check_idle(input string tag);
        vectors++;
        if (out_valid !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1 || out_mode !== 2'b00 ||
            p0 !== '0 || p1 !== '0 || p2 !== '0 || p3 !== '0) begin
            miscompares++;
            $display("FAIL %s: got ov=%b err=%b ir=%b mode=%b p0=%h p1=%h p2=%h p3=%h, required ov=0 err=0 ir=1 mode=00 p=0",
                     tag, out_valid, err, in_ready, out_mode, p0, p1, p2, p3);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset");
    endtask

    task automatic test_enc();
        send(2'b00, {32'h00000000, 32'h193de3be}, 1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL enc_latency1: got out_valid %b, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || p0 !== 64'hc66363a5_b3d4d467 || p1 !== 64'ha5c66363_694e2727 ||
            p2 !== 64'h63a5c663_11332211 || p3 !== 64'h6363a5c6_aeaee947) begin
            miscompares++;
            $display("FAIL enc_vec: got ov=%b p0=%h p1=%h p2=%h p3=%h, required ov=1 c66363a5b3d4d467 a5c66363694e2727 63a5c66311332211 6363a5c6aeaee947",
                     out_valid, p0, p1, p2, p3);
        end
        drain();
    endtask

    task automatic test_dec();
        send(2'b01, {32'h77000000, 32'h7c7c7c7c}, 1'b0);
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_mode !== 2'b01 || p0 !== 64'h1c121a16_0e090d0b ||
            p1[31:0] !== 32'h0b0e090d || p2[31:0] !== 32'h0d0b0e09 || p3[31:0] !== 32'h090d0b0e) begin
            miscompares++;
            $display("FAIL dec_vec: got ov=%b mode=%b p0=%h p1=%h p2=%h p3=%h, required 1c121a160e090d0b and lane0 0b0e090d 0d0b0e09 090d0b0e",
                     out_valid, out_mode, p0, p1, p2, p3);
        end
        drain();
    endtask

    task automatic test_last();
        send(2'b10, {32'h00000000, 32'h193de3be}, 1'b0);
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_mode !== 2'b10 || p0 !== 64'h63000000_d4000000 ||
            p1 !== 64'h00630000_00270000 || p2 !== 64'h00006300_00001100 || p3 !== 64'h00000063_000000ae) begin
            miscompares++;
            $display("FAIL last_vec: got ov=%b mode=%b p0=%h p1=%h p2=%h p3=%h", out_valid, out_mode, p0, p1, p2, p3);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [4*W-1:0] held;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_mode = 2'b00;
        in_state = {32'h01234567, 32'h89abcdef};
        @(posedge clk);
        #1;
        in_mode = 2'b01;
        in_state = {32'hdeadbeef, 32'h0badf00d};
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_mode = 2'b10;
        in_state = {32'hcafebabe, 32'h13572468};
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_mode !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_full: got ir=%b ov=%b mode=%b, required ir=0 ov=1 mode=00", in_ready, out_valid, out_mode);
        end
        held = {p3, p2, p1, p0};
        repeat (2) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({p3, p2, p1, p0} !== held || out_valid !== 1'b1 || out_mode !== 2'b00 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_stall: got ov=%b mode=%b ir=%b p=%h, required held p=%h", out_valid, out_mode, in_ready, {p3, p2, p1, p0}, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_mode !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_second: got ov=%b mode=%b, required ov=1 mode=01", out_valid, out_mode);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_mode !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_third: got ov=%b mode=%b, required ov=1 mode=10", out_valid, out_mode);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_empty: got ov=%b, required 0", out_valid);
        end
        drain();
    endtask

    task automatic test_reserved();
        send(2'b11, {$urandom, $urandom}, 1'b0);
        drain();
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_set: got %b, required 1", err);
        end
        send(2'b00, {$urandom, $urandom}, 1'b0);
        drain();
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: got %b, required 1", err);
        end
        out_ready = 1'b0;
        send(2'b00, {$urandom, $urandom}, 1'b0);
        send(2'b01, {$urandom, $urandom}, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL inflight: got ov=%b ir=%b, required ov=1 ir=0", out_valid, in_ready);
        end
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        check_idle("reset_flush");
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_no_ghost: got ov=%b, required 0", out_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            send(2'($urandom_range(0, 2)), {$urandom, $urandom}, 1'b1);
        end
        out_ready = 1'b1;
        drain();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: got %b, required 0", err);
        end
    endtask

    initial begin
        logic [7:0] inv;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
            sb_t[a] = s;
            isb_t[s] = 8'(a);
        end
        test_reset();
        test_enc();
        test_dec();
        test_last();
        test_back_to_back();
        test_reserved();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
